axi_addr_ch_txq: RTL

- Queued, parametrised AXI address-channel transmitter (AR or AW) between the RAB translation logic and the downstream slave (memory system or interconnect).
- Buffers up to DEPTH translated requests and issues them in order, so the translation logic is not stalled by a single outstanding handshake.
- Adds backpressure to the translation logic (t_ready), full-throughput push/pop, and discard-with-report of faulted translations.

---
 rtl/axi_addr_ch_txq_if.sv | 32 +++
 rtl/axi_addr_ch_txq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/axi_addr_ch_txq_if.sv
// AXI address-channel bundle (AR or AW) between the request queue and the
// downstream slave. The master drives the address fields and VALID, the
// slave answers with READY.
interface axi_addr_ch_txq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2
);
  logic [ID_WIDTH-1:0]   out_id;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [7:0]            out_len;
  logic [2:0]            out_size;
  logic [1:0]            out_burst;
  logic [2:0]            out_prot;
  logic [3:0]            out_cache;
  logic [USER_WIDTH-1:0] out_user;
  logic                  out_lock;
  logic                  out_valid;
  logic                  in_ready;

  modport master (
    output out_id, out_addr, out_len, out_size, out_burst,
           out_prot, out_cache, out_user, out_lock, out_valid,
    input  in_ready
  );

  modport slave (
    input  out_id, out_addr, out_len, out_size, out_burst,
           out_prot, out_cache, out_user, out_lock, out_valid,
    output in_ready
  );
endinterface

// File: rtl/axi_addr_ch_txq.sv
// Queued AXI address-channel transmitter. Translated requests are buffered
// in a small in-order queue so the translation logic never waits on a single
// outstanding handshake; faulted translations are dropped and reported.
module axi_addr_ch_txq #(
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int USER_WIDTH    = 2,
  parameter int DEPTH         = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                         tx_clk,
  input  logic                         reset_,
  input  logic [ID_WIDTH-1:0]          in_id,
  input  logic [7:0]                   in_len,
  input  logic [2:0]                   in_size,
  input  logic [1:0]                   in_burst,
  input  logic [2:0]                   in_prot,
  input  logic [3:0]                   in_cache,
  input  logic [USER_WIDTH-1:0]        in_user,
  input  logic                         in_lock,
  input  logic [ADDR_WIDTH-1:0]        phy_addr,
  input  logic                         t_done,
  input  logic                         t_err,
  output logic                         t_ready,
  axi_addr_ch_txq_if.master            axi,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         err_valid,
  output logic [ID_WIDTH-1:0]          err_id,
  output logic [ERR_CNT_WIDTH-1:0]     err_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [2:0]            prot;
    logic [3:0]            cache;
    logic [USER_WIDTH-1:0] user;
    logic                  lock;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head_q;
  entry_t            head_d;
  entry_t            in_entry;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [LVL_W-1:0]  remain;
  logic [LVL_W-1:0]  level_d;
  logic              out_valid_q;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fault;
  logic              head_load;

  // Handshake decode and next head/level. The head register is reloaded when
  // the current head leaves or the queue is empty; it takes the next stored
  // entry if one remains, otherwise the incoming request (bypassing the
  // array write that happens on the same edge). With nothing to load it
  // holds, so an empty queue keeps showing the last popped entry.
  always_comb begin
    in_entry  = '{id: in_id, addr: phy_addr, len: in_len, size: in_size,
                  burst: in_burst, prot: in_prot, cache: in_cache,
                  user: in_user, lock: in_lock};
    t_ready   = (level != FULL_LVL);
    accept    = t_done & t_ready;
    push      = accept & ~t_err;
    fault     = accept & t_err;
    pop       = out_valid_q & axi.in_ready;
    rd_next   = rd_ptr + PTR_W'(1);
    remain    = level - LVL_W'(pop);
    level_d   = remain + LVL_W'(push);
    head_load = (pop || (level == '0)) && ((remain != '0) || push);
    head_d    = (remain != '0) ? mem[rd_next] : in_entry;
  end

  // Queue storage; contents need no reset because the level gates their use.
  always_ff @(posedge tx_clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // Pointers, level, registered head/VALID and the fault reporting state.
  always_ff @(posedge tx_clk) begin
    if (!reset_) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      err_valid   <= 1'b0;
      err_id      <= '0;
      err_cnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_next;
      if (head_load) head_q <= head_d;
      level       <= level_d;
      out_valid_q <= (level_d != '0);
      err_valid   <= fault;
      if (fault) begin
        err_id <= in_id;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign axi.out_id    = head_q.id;
  assign axi.out_addr  = head_q.addr;
  assign axi.out_len   = head_q.len;
  assign axi.out_size  = head_q.size;
  assign axi.out_burst = head_q.burst;
  assign axi.out_prot  = head_q.prot;
  assign axi.out_cache = head_q.cache;
  assign axi.out_user  = head_q.user;
  assign axi.out_lock  = head_q.lock;
  assign axi.out_valid = out_valid_q;
endmodule
